// File: rtl/alu_div32.sv
// alu_div32: iterative radix-2 restoring divider, signed or unsigned, one
// quotient bit per clock, start/busy/done handshake, ALU-style result flags.
// Optional macro ALU_DIV_EARLY_EN: skip the iteration loop when the divisor
// is zero or |dividend| < |divisor|, completing one edge after start.
module alu_div32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op1,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rem,
  output logic             zero,
  output logic             N,
  output logic             overflow,
  output logic             divz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  state_t           w_next;

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_pr;      // 33-bit partial remainder
  logic [WIDTH-1:0] r_q;       // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0] r_dvs;     // divisor magnitude
  logic [WIDTH-1:0] r_a_raw;   // dividend as presented, for divide-by-zero remainder
  logic             r_signed;
  logic             r_neg_a;
  logic             r_neg_b;
  logic             r_divz;
  logic             r_ovf;

  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_rem;
  logic             r_zero;
  logic             r_n;
  logic             r_overflow;
  logic             r_divz_o;

  // Operand decode at the start edge
  logic             w_sgn;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_early;

  assign w_sgn   = (op1 == 4'b0001);
  assign w_neg_a = w_sgn && in0[WIDTH-1];
  assign w_neg_b = w_sgn && in1[WIDTH-1];
  assign w_mag_a = w_neg_a ? -in0 : in0;
  assign w_mag_b = w_neg_b ? -in1 : in1;

`ifdef ALU_DIV_EARLY_EN
  assign w_early = (in1 == '0) || (w_mag_a < w_mag_b);
`else
  assign w_early = 1'b0;
`endif

  // One restoring iteration: shift, trial subtract, keep if non-negative
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_keep;

  assign w_shift = {r_pr, r_q[WIDTH-1]};
  assign w_diff  = w_shift - {2'b00, r_dvs};
  assign w_keep  = ~w_diff[WIDTH+1];

  // Sign correction and special-case overrides applied in FIX
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [WIDTH-1:0] w_out;
  logic [WIDTH-1:0] w_rem;

  assign w_q_fix = (r_neg_a ^ r_neg_b) ? -r_q : r_q;
  assign w_r_fix = r_neg_a ? -r_pr[WIDTH-1:0] : r_pr[WIDTH-1:0];
  assign w_out   = r_divz ? '1      : (r_ovf ? MIN_NEG : w_q_fix);
  assign w_rem   = r_divz ? r_a_raw : (r_ovf ? '0      : w_r_fix);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = w_early ? FIX : CALC;
      CALC:    if (r_cnt == CNT_W'(WIDTH-1)) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, result registration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_pr       <= '0;
      r_q        <= '0;
      r_dvs      <= '0;
      r_a_raw    <= '0;
      r_signed   <= 1'b0;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
      r_divz     <= 1'b0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_out      <= '0;
      r_rem      <= '0;
      r_zero     <= 1'b0;
      r_n        <= 1'b0;
      r_overflow <= 1'b0;
      r_divz_o   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_signed <= w_sgn;
            r_neg_a  <= w_neg_a;
            r_neg_b  <= w_neg_b;
            r_dvs    <= w_mag_b;
            r_a_raw  <= in0;
            r_divz   <= (in1 == '0);
            r_ovf    <= w_sgn && (in0 == MIN_NEG) && (in1 == '1);
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            // Early exit lands in FIX with quotient 0 and remainder |in0|,
            // so the normal sign fix-up restores in0 as the remainder.
            if (w_early) begin
              r_pr <= {1'b0, w_mag_a};
              r_q  <= '0;
            end else begin
              r_pr <= '0;
              r_q  <= w_mag_a;
            end
          end
        end
        CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_keep) r_pr <= w_diff[WIDTH:0];
          else        r_pr <= w_shift[WIDTH:0];
          r_q <= {r_q[WIDTH-2:0], w_keep};
        end
        FIX: begin
          r_out      <= w_out;
          r_rem      <= w_rem;
          r_zero     <= (w_out == '0);
          r_n        <= w_out[WIDTH-1];
          r_overflow <= r_ovf && !r_divz;
          r_divz_o   <= r_divz;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign out      = r_out;
  assign rem      = r_rem;
  assign zero     = r_zero;
  assign N        = r_n;
  assign overflow = r_overflow;
  assign divz     = r_divz_o;

endmodule
